// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALTED,
    ST_FAULT
  } state_t;

  localparam int CTRL_BITS        = 9;
  localparam int REG_ADDR_W       = 5;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_MEM_TIMEOUT  = 255;
  localparam int DEF_CNT_WIDTH    = 32;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID/EX destination and IF/ID sources.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                  i_idExMemRead,
  input  logic [REG_ADDR_W-1:0] i_idExWriteRegister,
  input  logic [REG_ADDR_W-1:0] i_ifIdRs,
  input  logic [REG_ADDR_W-1:0] i_ifIdRt,
  input  logic                  i_ifIdUsesRt,
  output logic                  o_loadUse
);

  logic w_rsHit;
  logic w_rtHit;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_rsHit   = (i_idExWriteRegister == i_ifIdRs);
  assign w_rtHit   = i_ifIdUsesRt && (i_idExWriteRegister == i_ifIdRt);
  assign o_loadUse = i_idExMemRead && (i_idExWriteRegister != '0) && (w_rsHit || w_rtHit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-cycle advance/freeze/bubble decisions for the 5-stage pipeline, plus
// saturating stall and flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  idExMemRead,
  input  logic [REG_ADDR_W-1:0] idExWriteRegister,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRt,
  input  logic                  branchTaken,
  input  logic                  exMemMemAccess,
  input  logic                  memReady,
  input  logic                  haltDecoded,
  input  logic                  resume,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  ifIdFlush,
  output logic                  idExBubble,
  output logic                  pipeEnable,
  output logic                  halted,
  output logic                  memTimeout,
  output logic [CNT_WIDTH-1:0]  stallCount,
  output logic [CNT_WIDTH-1:0]  flushCount
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               r_state, r_retState, w_nextState, w_nextRet, w_evalState;
  logic [WAIT_W-1:0]    r_waitCnt, w_nextWait;
  logic [DRAIN_W-1:0]   r_drainCnt, w_nextDrain;
  logic [CNT_WIDTH-1:0] r_stallCount, r_flushCount;
  logic                 r_memTimeout;
  logic                 w_loadUse, w_memStall, w_eval;
  logic                 w_stallInc, w_flushInc, w_setTimeout;

  load_use_detect u_load_use_detect (
    .i_idExMemRead       (idExMemRead),
    .i_idExWriteRegister (idExWriteRegister),
    .i_ifIdRs            (ifIdRs),
    .i_ifIdRt            (ifIdRt),
    .i_ifIdUsesRt        (ifIdUsesRt),
    .o_loadUse           (w_loadUse)
  );

  assign w_memStall = exMemMemAccess && !memReady;

  always_comb begin
    w_nextState  = r_state;
    w_nextRet    = r_retState;
    w_nextWait   = r_waitCnt;
    w_nextDrain  = r_drainCnt;
    w_stallInc   = 1'b0;
    w_flushInc   = 1'b0;
    w_setTimeout = 1'b0;
    w_eval       = 1'b0;
    w_evalState  = ST_RUN;
    pcWrite      = 1'b0;
    ifIdWrite    = 1'b0;
    ifIdFlush    = 1'b0;
    idExBubble   = 1'b0;
    pipeEnable   = 1'b0;

    case (r_state)
      ST_RUN, ST_DRAIN: begin
        if (w_memStall) begin
          w_nextRet   = r_state;
          w_nextWait  = WAIT_W'(1);
          w_nextState = ST_MEM_WAIT;
          w_stallInc  = 1'b1;
        end else begin
          w_eval      = 1'b1;
          w_evalState = r_state;
        end
      end
      ST_MEM_WAIT: begin
        if (!memReady) begin
          w_stallInc = 1'b1;
          w_nextWait = r_waitCnt + WAIT_W'(1);
          // This frozen cycle is the MEM_TIMEOUT-th in a row.
          if (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            w_nextState  = ST_FAULT;
            w_setTimeout = 1'b1;
          end
        end else begin
          w_eval      = 1'b1;
          w_evalState = r_retState;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          pcWrite     = 1'b1;
          ifIdWrite   = 1'b1;
          idExBubble  = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      default: ;
    endcase

    // Advancing cycle: branch beats everything, then drain / load-use / halt.
    if (w_eval) begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      pipeEnable = 1'b1;
      if (branchTaken) begin
        ifIdFlush   = 1'b1;
        idExBubble  = 1'b1;
        w_flushInc  = 1'b1;
        w_nextState = ST_RUN;
      end else if (w_evalState == ST_DRAIN) begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        if (r_drainCnt == '0) begin
          w_nextState = ST_HALTED;
        end else begin
          w_nextDrain = r_drainCnt - DRAIN_W'(1);
          w_nextState = ST_DRAIN;
        end
      end else if (w_loadUse) begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExBubble  = 1'b1;
        w_stallInc  = 1'b1;
        w_nextState = ST_RUN;
      end else if (haltDecoded) begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExBubble  = 1'b1;
        w_nextDrain = DRAIN_W'(DRAIN_CYCLES - 1);
        w_nextState = ST_DRAIN;
      end else begin
        w_nextState = ST_RUN;
      end
    end

    if (!resetN) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
      pipeEnable = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= ST_RUN;
      r_retState   <= ST_RUN;
      r_waitCnt    <= '0;
      r_drainCnt   <= '0;
      r_stallCount <= '0;
      r_flushCount <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_retState   <= w_nextRet;
      r_waitCnt    <= w_nextWait;
      r_drainCnt   <= w_nextDrain;
      r_memTimeout <= r_memTimeout | w_setTimeout;
      if (w_stallInc) r_stallCount <= sat_inc(r_stallCount);
      if (w_flushInc) r_flushCount <= sat_inc(r_flushCount);
    end
  end

  assign halted     = (r_state == ST_HALTED);
  assign memTimeout = r_memTimeout;
  assign stallCount = r_stallCount;
  assign flushCount = r_flushCount;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: expected control vectors are queued as stimulus is driven.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetN, idExMemRead, ifIdUsesRt, branchTaken;
  logic          exMemMemAccess, memReady, haltDecoded, resume;
  logic [4:0]    idExWriteRegister, ifIdRs, ifIdRt;
  logic          pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeEnable, halted, memTimeout;
  logic [CW-1:0] stallCount, flushCount;
  logic [5:0]    outv;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(255), .CNT_WIDTH(CW)) dut (
    .clock(clock), .resetN(resetN), .idExMemRead(idExMemRead),
    .idExWriteRegister(idExWriteRegister), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
    .ifIdUsesRt(ifIdUsesRt), .branchTaken(branchTaken), .exMemMemAccess(exMemMemAccess),
    .memReady(memReady), .haltDecoded(haltDecoded), .resume(resume),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExBubble(idExBubble), .pipeEnable(pipeEnable), .halted(halted),
    .memTimeout(memTimeout), .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  // {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeEnable, halted}
  assign outv = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeEnable, halted};

  localparam logic [5:0] ALL   = 6'b111111;
  localparam logic [5:0] NOH   = 6'b111110;
  localparam logic [5:0] P_RUN = 6'b110010;
  localparam logic [5:0] P_RST = 6'b001100;
  localparam logic [5:0] P_FRZ = 6'b000000;
  localparam logic [5:0] P_LU  = 6'b000110;
  localparam logic [5:0] P_BR  = 6'b101100;
  localparam logic [5:0] C_BR  = 6'b101100;
  localparam logic [5:0] P_HD  = 6'b000100;
  localparam logic [5:0] C_HD  = 6'b110101;
  localparam logic [5:0] P_DR  = 6'b000110;
  localparam logic [5:0] P_HT  = 6'b000001;
  localparam logic [5:0] P_RS  = 6'b110101;
  localparam logic [5:0] C_RS  = 6'b110101;

  typedef struct {
    string      nm;
    logic       rstN, rd;
    logic [4:0] wr, rs, rt;
    logic       ur, br, acc, rdy, hlt, res;
    logic [5:0] exp, care;
  } step_t;

  typedef struct {
    string      nm;
    logic [5:0] exp, care;
  } exp_t;

  exp_t sb[$];
  int   nAssert = 0;
  int   nFail   = 0;

  function automatic step_t S(input string nm, input logic rstN, input logic rd,
                              input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic br, input logic acc, input logic rdy,
                              input logic hlt, input logic res, input logic [5:0] exp,
                              input logic [5:0] care);
    step_t s;
    s.nm = nm; s.rstN = rstN; s.rd = rd; s.wr = wr; s.rs = rs; s.rt = rt; s.ur = ur;
    s.br = br; s.acc = acc; s.rdy = rdy; s.hlt = hlt; s.res = res; s.exp = exp; s.care = care;
    return s;
  endfunction

  // Common step shapes: idle, frozen memory access, halt held in IF/ID.
  function automatic step_t IDLE(input string nm, input logic [5:0] exp, input logic [5:0] care);
    return S(nm, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, exp, care);
  endfunction
  function automatic step_t MEMW(input string nm, input logic hlt);
    return S(nm, 1, 0, 0, 0, 0, 0, 0, 1, 0, hlt, 0, P_FRZ, ALL);
  endfunction
  function automatic step_t HALT(input string nm, input logic [5:0] exp, input logic [5:0] care);
    return S(nm, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, exp, care);
  endfunction

  task automatic drive(input step_t s);
    exp_t e;
    resetN = s.rstN; idExMemRead = s.rd; idExWriteRegister = s.wr; ifIdRs = s.rs;
    ifIdRt = s.rt; ifIdUsesRt = s.ur; branchTaken = s.br; exMemMemAccess = s.acc;
    memReady = s.rdy; haltDecoded = s.hlt; resume = s.res;
    e.nm = s.nm; e.exp = s.exp; e.care = s.care;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st = '{S("reset_outputs", 0, 1, 8, 8, 8, 1, 1, 1, 0, 1, 1, P_RST, NOH),
           S("reset_outputs", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_RST, NOH)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (stallCount !== '0) begin nFail++; $display("FAIL reset_stall: got %0d, required 0", stallCount); end
    nAssert++;
    if (flushCount !== '0) begin nFail++; $display("FAIL reset_flush: got %0d, required 0", flushCount); end
    nAssert++;
    if (memTimeout !== 1'b0) begin nFail++; $display("FAIL reset_timeout: got %b, required 0", memTimeout); end
    nAssert++;
    if (halted !== 1'b0) begin nFail++; $display("FAIL reset_halted: got %b, required 0", halted); end
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    st = '{S("lu_rs_match", 1, 1, 8, 8, 3, 1, 0, 0, 1, 0, 0, P_LU, ALL),
           S("lu_after_bubble", 1, 0, 0, 8, 3, 1, 0, 0, 1, 0, 0, P_RUN, ALL),
           S("lu_rt_match", 1, 1, 8, 3, 8, 1, 0, 0, 1, 0, 0, P_LU, ALL),
           S("lu_rt_not_used", 1, 1, 8, 3, 8, 0, 0, 0, 1, 0, 0, P_RUN, ALL),
           S("lu_zero_reg", 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, P_RUN, ALL),
           IDLE("lu_idle", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
      if (i == 0) begin
        nAssert++;
        if (stallCount !== 4'd1) begin nFail++; $display("FAIL lu_stall_one: got %0d, required 1", stallCount); end
      end
    end
    nAssert++;
    if (stallCount !== 4'd2) begin nFail++; $display("FAIL lu_stall_total: got %0d, required 2", stallCount); end
  endtask

  task automatic test_branch_load_use();
    step_t st[$];
    exp_t  e;
    st = '{S("br_over_lu", 1, 1, 8, 8, 3, 1, 1, 0, 1, 0, 0, P_BR, C_BR),
           IDLE("br_after", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (flushCount !== 4'd1) begin nFail++; $display("FAIL br_flush: got %0d, required 1", flushCount); end
    nAssert++;
    if (stallCount !== 4'd2) begin nFail++; $display("FAIL br_stall: got %0d, required 2", stallCount); end
  endtask

  task automatic test_mem_wait();
    step_t st[$];
    exp_t  e;
    for (int k = 0; k < 4; k++) st.push_back(MEMW("mem_frozen", 0));
    st.push_back(S("mem_release", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, P_RUN, ALL));
    st.push_back(IDLE("mem_idle", P_RUN, ALL));
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (stallCount !== 4'd6) begin nFail++; $display("FAIL mem_stall: got %0d, required 6", stallCount); end
  endtask

  task automatic test_halt_resume();
    step_t st[$];
    exp_t  e;
    st.push_back(HALT("halt_decode", P_HD, C_HD));
    for (int k = 0; k < 3; k++) st.push_back(HALT("drain", P_DR, ALL));
    st.push_back(HALT("halted", P_HT, ALL));
    st.push_back(HALT("halted_hold", P_HT, ALL));
    st.push_back(S("resume", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_RS, C_RS));
    st.push_back(IDLE("after_resume", P_RUN, ALL));
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch_in_drain();
    step_t st[$];
    exp_t  e;
    st = '{HALT("bd_halt_decode", P_HD, C_HD),
           S("bd_branch", 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, P_BR, C_BR),
           IDLE("bd_back_to_run", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (flushCount !== 4'd2) begin nFail++; $display("FAIL bd_flush: got %0d, required 2", flushCount); end
  endtask

  task automatic test_drain_mem_wait();
    step_t st[$];
    exp_t  e;
    st = '{HALT("dm_halt_decode", P_HD, C_HD),
           HALT("dm_drain1", P_DR, ALL),
           MEMW("dm_frozen1", 1),
           MEMW("dm_frozen2", 1),
           S("dm_release", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, P_DR, ALL),
           HALT("dm_drain3", P_DR, ALL),
           HALT("dm_halted", P_HT, ALL),
           S("dm_resume", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_RS, C_RS),
           IDLE("dm_run", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (stallCount !== 4'd8) begin nFail++; $display("FAIL dm_stall: got %0d, required 8", stallCount); end
  endtask

  task automatic test_reset_mid_wait();
    step_t st[$];
    exp_t  e;
    st = '{MEMW("rw_frozen1", 0),
           MEMW("rw_frozen2", 0),
           S("rw_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, P_RST, NOH),
           IDLE("rw_run", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (stallCount !== '0) begin nFail++; $display("FAIL rw_stall: got %0d, required 0", stallCount); end
    nAssert++;
    if (flushCount !== '0) begin nFail++; $display("FAIL rw_flush: got %0d, required 0", flushCount); end
  endtask

  task automatic test_timeout();
    step_t st[$];
    exp_t  e;
    for (int k = 0; k < 260; k++) st.push_back(MEMW("to_frozen", 0));
    st.push_back(IDLE("to_fault_hold", P_FRZ, ALL));
    st.push_back(IDLE("to_fault_hold", P_FRZ, ALL));
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
      if (i == 249) begin
        nAssert++;
        if (memTimeout !== 1'b0) begin nFail++; $display("FAIL to_early: memTimeout %b, required 0", memTimeout); end
        nAssert++;
        if (stallCount !== 4'hF) begin nFail++; $display("FAIL to_saturate: got %0d, required 15", stallCount); end
      end
    end
    nAssert++;
    if (memTimeout !== 1'b1) begin nFail++; $display("FAIL to_sticky: memTimeout %b, required 1", memTimeout); end
    st.delete();
    st = '{S("to_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_RST, NOH),
           IDLE("to_run", P_RUN, ALL)};
    foreach (st[i]) begin
      drive(st[i]);
      @(negedge clock);
      e = sb.pop_front();
      nAssert++;
      if ((outv & e.care) !== (e.exp & e.care)) begin
        nFail++;
        $display("FAIL %s: outputs %b, required %b (mask %b)", e.nm, outv, e.exp, e.care);
      end
      @(posedge clock); #1;
    end
    nAssert++;
    if (memTimeout !== 1'b0) begin nFail++; $display("FAIL to_cleared: memTimeout %b, required 0", memTimeout); end
    nAssert++;
    if (stallCount !== '0) begin nFail++; $display("FAIL to_stall_cleared: got %0d, required 0", stallCount); end
  endtask

  initial begin
    resetN = 1'b0; idExMemRead = 1'b0; idExWriteRegister = '0; ifIdRs = '0; ifIdRt = '0;
    ifIdUsesRt = 1'b0; branchTaken = 1'b0; exMemMemAccess = 1'b0; memReady = 1'b1;
    haltDecoded = 1'b0; resume = 1'b0;
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_halt_resume();
    test_branch_in_drain();
    test_drain_mem_wait();
    test_reset_mid_wait();
    test_timeout();
    nAssert++;
    if (sb.size() != 0) begin nFail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
